// File: rtl/jmp_resolve_unit.sv
// Branch/jump resolution between decode and fetch.
// Resolves in-flight branches, redirects fetch and stalls hazardous JALR.
module jmp_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BR_LAT    = 2,
  parameter int HAZ_DEPTH = 2,
  parameter int REG_BITS  = 6,
  parameter int PC_ADJ    = 8,
  parameter int CNT_W     = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_new_jmp,
  input  logic [2:0]                    i_jmp_type,
  input  logic [REG_BITS-1:0]           i_jal_rs,
  input  logic [REG_BITS-1:0]           i_rd,
  input  logic [XLEN-1:0]               i_busJ,
  input  logic [XLEN-1:0]               i_imm,
  input  logic [XLEN-1:0]               i_pc,
  input  logic                          i_zero,
  input  logic                          i_bit_bus_C,
  output logic [XLEN-1:0]               o_new_pc,
  output logic                          o_ctrl_fetch,
  output logic                          o_reset_branch,
  output logic                          o_reset_jal,
  output logic                          o_halt,
  output logic                          o_squash,
  output logic                          o_pending,
  output logic [HAZ_DEPTH*REG_BITS-1:0] o_hazard_rd,
  output logic [CNT_W-1:0]              o_taken_cnt,
  output logic [CNT_W-1:0]              o_stall_cnt
);

  localparam int OLD = BR_LAT - 1;

  logic [BR_LAT-1:0]   r_vld;
  logic [2:0]          r_typ [BR_LAT];
  logic [XLEN-1:0]     r_tgt [BR_LAT];
  logic [REG_BITS-1:0] r_hist [HAZ_DEPTH];
  logic [CNT_W-1:0]    r_taken;
  logic [CNT_W-1:0]    r_stall;
  logic                r_rst_br;
  logic                r_rst_jal;

  logic w_cond;
  logic w_br_take;
  logic w_jal_req;
  logic w_hz_hit;
  logic w_hz;
  logic w_halt;
  logic w_jal_fire;
  logic w_load;

  // Condition of the oldest in-flight branch against the ALU flags
  always_comb begin
    w_cond = 1'b0;
    case (r_typ[OLD])
      3'b000:  w_cond = i_zero;
      3'b001:  w_cond = ~i_zero;
      3'b100,
      3'b110:  w_cond = i_bit_bus_C;
      3'b101,
      3'b111:  w_cond = ~i_bit_bus_C;
      default: w_cond = 1'b0;
    endcase
  end

  // JALR source compared with recent destinations
  always_comb begin
    w_hz_hit = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++)
      if (r_hist[i] == i_jal_rs) w_hz_hit = 1'b1;
    w_hz = w_hz_hit & (i_jal_rs != '0);
  end

  assign w_br_take  = r_vld[OLD] & w_cond;
  assign w_jal_req  = i_new_jmp & (i_jmp_type[2:1] == 2'b01);
  assign w_halt     = w_jal_req & ~w_br_take & (o_pending | w_hz);
  assign w_jal_fire = w_jal_req & ~w_halt & ~w_br_take;
  assign w_load     = i_new_jmp & ~w_jal_req & ~w_halt & ~w_br_take;

  assign o_pending    = |r_vld;
  assign o_halt       = w_halt;
  assign o_squash     = w_br_take;
  assign o_ctrl_fetch = w_br_take | w_jal_fire;
  assign o_new_pc     = w_br_take  ? r_tgt[OLD] :
                        w_jal_fire ? i_imm + i_busJ : '0;

  assign o_reset_branch = r_rst_br;
  assign o_reset_jal    = r_rst_jal;
  assign o_taken_cnt    = r_taken;
  assign o_stall_cnt    = r_stall;

  for (genvar g = 0; g < HAZ_DEPTH; g++) begin : g_hz
    assign o_hazard_rd[g*REG_BITS +: REG_BITS] = r_hist[g];
  end

  // Branch pipe: load, advance, flush on a taken branch
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_vld <= '0;
      for (int i = 0; i < BR_LAT; i++) begin
        r_typ[i] <= '0;
        r_tgt[i] <= '0;
      end
    end else if (w_br_take) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_load;
      r_typ[0] <= i_jmp_type;
      r_tgt[0] <= i_imm + i_pc - XLEN'(PC_ADJ);
      for (int i = 1; i < BR_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_typ[i] <= r_typ[i-1];
        r_tgt[i] <= r_tgt[i-1];
      end
    end
  end

  // Destination history; stalled slots insert no destination
  always_ff @(posedge i_clock) begin
    if (i_reset || w_br_take) begin
      for (int i = 0; i < HAZ_DEPTH; i++) r_hist[i] <= '0;
    end else begin
      r_hist[0] <= w_halt ? '0 : i_rd;
      for (int i = 1; i < HAZ_DEPTH; i++) r_hist[i] <= r_hist[i-1];
    end
  end

  // Flush pulses and saturating event counters
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rst_br  <= 1'b0;
      r_rst_jal <= 1'b0;
      r_taken   <= '0;
      r_stall   <= '0;
    end else begin
      r_rst_br  <= w_br_take;
      r_rst_jal <= w_jal_fire;
      if (w_br_take && r_taken != '1) r_taken <= r_taken + 1'b1;
      if (w_halt && r_stall != '1) r_stall <= r_stall + 1'b1;
    end
  end

endmodule

// File: tb/tb_jmp_resolve_unit.sv
// Directed bench for jmp_resolve_unit.
// Second instance with narrow counters exercises saturation.
module tb_jmp_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        nj;
  logic [2:0]  typ;
  logic [5:0]  jrs, rd;
  logic [31:0] busj, imm, pc;
  logic        zero, cbit;

  logic [31:0] new_pc;
  logic        ctrl, rbr, rjal, halt, squash, pend;
  logic [11:0] hrd;
  logic [15:0] tcnt, scnt;

  logic [31:0] s_pc;
  logic        s_ctrl, s_rbr, s_rjal, s_halt, s_sq, s_pend;
  logic [11:0] s_hrd;
  logic [1:0]  s_tcnt, s_scnt;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jmp_resolve_unit u_dut (
    .i_clock(clk), .i_reset(rst), .i_new_jmp(nj),
    .i_jmp_type(typ), .i_jal_rs(jrs), .i_rd(rd),
    .i_busJ(busj), .i_imm(imm), .i_pc(pc),
    .i_zero(zero), .i_bit_bus_C(cbit),
    .o_new_pc(new_pc), .o_ctrl_fetch(ctrl),
    .o_reset_branch(rbr), .o_reset_jal(rjal),
    .o_halt(halt), .o_squash(squash), .o_pending(pend),
    .o_hazard_rd(hrd), .o_taken_cnt(tcnt), .o_stall_cnt(scnt)
  );

  jmp_resolve_unit #(.CNT_W(2)) u_sat (
    .i_clock(clk), .i_reset(rst), .i_new_jmp(nj),
    .i_jmp_type(typ), .i_jal_rs(jrs), .i_rd(rd),
    .i_busJ(busj), .i_imm(imm), .i_pc(pc),
    .i_zero(zero), .i_bit_bus_C(cbit),
    .o_new_pc(s_pc), .o_ctrl_fetch(s_ctrl),
    .o_reset_branch(s_rbr), .o_reset_jal(s_rjal),
    .o_halt(s_halt), .o_squash(s_sq), .o_pending(s_pend),
    .o_hazard_rd(s_hrd), .o_taken_cnt(s_tcnt), .o_stall_cnt(s_scnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one edge; inputs change 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle (checks land on the falling edge)
  task automatic mid();
    #4;
  endtask

  task automatic idle();
    nj = 0; typ = 0; jrs = 0; rd = 0;
    busj = 0; imm = 0; pc = 0; zero = 0; cbit = 0;
  endtask

  task automatic jmp(input logic [2:0] t, input logic [31:0] p,
                     input logic [31:0] i, input logic [31:0] b,
                     input logic [5:0] rs);
    nj = 1; typ = t; pc = p; imm = i; busj = b; jrs = rs;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    do_reset();
    mid();
    chk("rst_pend",  {31'd0, pend}, 0);
    chk("rst_ctrl",  {31'd0, ctrl}, 0);
    chk("rst_npc",   new_pc, 0);
    chk("rst_hrd",   {20'd0, hrd}, 0);
    chk("rst_cnt",   {tcnt, scnt}, 0);
    chk("rst_flush", {30'd0, rbr, rjal}, 0);

    // BEQ taken after BR_LAT cycles, target = 0x100+0x40-8
    tick();
    jmp(3'b000, 32'h100, 32'h40, 0, 0);
    mid();
    chk("t1_c0_ctrl", {31'd0, ctrl}, 0);
    tick(); idle(); mid();
    chk("t1_c1_pend", {31'd0, pend}, 1);
    chk("t1_c1_ctrl", {31'd0, ctrl}, 0);
    tick(); zero = 1; mid();
    chk("t1_ctrl",   {31'd0, ctrl}, 1);
    chk("t1_npc",    new_pc, 32'h138);
    chk("t1_squash", {31'd0, squash}, 1);
    tick(); idle(); mid();
    chk("t1_rbr",  {31'd0, rbr}, 1);
    chk("t1_ctrl2", {31'd0, ctrl}, 0);
    chk("t1_tcnt", {16'd0, tcnt}, 1);
    chk("t1_pend", {31'd0, pend}, 0);

    // BNE then BEQ; BNE taken squashes BEQ
    do_reset();
    jmp(3'b001, 32'h100, 32'h20, 0, 0);
    tick();
    jmp(3'b000, 32'h104, 32'h80, 0, 0);
    tick(); idle(); mid();
    chk("t2_ctrl", {31'd0, ctrl}, 1);
    chk("t2_npc",  new_pc, 32'h118);
    chk("t2_sq",   {31'd0, squash}, 1);
    tick(); zero = 1; mid();
    chk("t2_noresv", {31'd0, ctrl}, 0);
    chk("t2_pend",   {31'd0, pend}, 0);
    tick(); idle(); mid();
    chk("t2_tcnt", {16'd0, tcnt}, 1);

    // JAL with empty pipe fires same cycle
    do_reset();
    jmp(3'b010, 0, 32'h10, 32'h200, 0);
    mid();
    chk("t3_ctrl", {31'd0, ctrl}, 1);
    chk("t3_npc",  new_pc, 32'h210);
    chk("t3_halt", {31'd0, halt}, 0);
    tick(); idle(); mid();
    chk("t3_rjal", {31'd0, rjal}, 1);
    chk("t3_ctrl2", {31'd0, ctrl}, 0);

    // JALR with rs=0 never sees a hazard on zeroed history
    jmp(3'b011, 0, 32'h4, 32'h80, 0);
    mid();
    chk("t3b_ctrl", {31'd0, ctrl}, 1);
    chk("t3b_npc",  new_pc, 32'h84);

    // JALR rs=5 right after rd=5: stalls HAZ_DEPTH cycles, twice
    do_reset();
    for (int k = 0; k < 2; k++) begin
      rd = 5;
      tick(); rd = 0;
      jmp(3'b011, 0, 32'h24, 32'h1000, 5);
      mid();
      chk("t4_hrd",  {20'd0, hrd}, 32'h005);
      chk("t4_h1",   {31'd0, halt}, 1);
      chk("t4_c1",   {31'd0, ctrl}, 0);
      tick(); mid();
      chk("t4_h2",   {31'd0, halt}, 1);
      tick(); mid();
      chk("t4_h3",   {31'd0, halt}, 0);
      chk("t4_ctrl", {31'd0, ctrl}, 1);
      chk("t4_npc",  new_pc, 32'h1024);
      tick(); idle(); mid();
      chk("t4_scnt", {16'd0, scnt}, 2 * (k + 1));
      chk("t4_rjal", {31'd0, rjal}, 1);
    end
    chk("sat_scnt", {30'd0, s_scnt}, 3);

    // JAL behind BLT that resolves not taken
    do_reset();
    jmp(3'b100, 32'h300, 32'h10, 0, 0);
    tick();
    jmp(3'b010, 0, 32'h8, 32'h400, 0);
    mid();
    chk("t5_h1", {31'd0, halt}, 1);
    chk("t5_p1", {31'd0, pend}, 1);
    tick(); cbit = 0; mid();
    chk("t5_h2", {31'd0, halt}, 1);
    chk("t5_c2", {31'd0, ctrl}, 0);
    tick(); mid();
    chk("t5_h3",   {31'd0, halt}, 0);
    chk("t5_ctrl", {31'd0, ctrl}, 1);
    chk("t5_npc",  new_pc, 32'h408);
    tick(); idle(); mid();
    chk("t5_scnt", {16'd0, scnt}, 2);
    chk("t5_tcnt", {16'd0, tcnt}, 0);

    // BGEU taken when less-than bit is clear
    do_reset();
    jmp(3'b111, 32'h500, 32'h8, 0, 0);
    tick(); idle();
    tick(); cbit = 0; mid();
    chk("t5b_ctrl", {31'd0, ctrl}, 1);
    chk("t5b_npc",  new_pc, 32'h500);

    // reset with two branches in flight
    do_reset();
    jmp(3'b000, 32'h100, 32'h40, 0, 0);
    tick();
    jmp(3'b001, 32'h104, 32'h40, 0, 0);
    tick(); idle(); zero = 0; mid();
    chk("t6_pend0", {31'd0, pend}, 1);
    rst = 1;
    tick(); rst = 0; zero = 1; mid();
    chk("t6_pend", {31'd0, pend}, 0);
    chk("t6_ctrl", {31'd0, ctrl}, 0);
    chk("t6_cnt",  {tcnt, scnt}, 0);
    tick(); zero = 0; mid();
    chk("t6_ctrl2", {31'd0, ctrl}, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
